// File: rtl/dfu_pkg.sv
// Shared constants and types for the DFU boot sequencer: DFU state codes,
// sequencer state encoding and a saturating-decrement helper.
package dfu_pkg;

   localparam logic [7:0] DFU_APP_IDLE            = 8'd0;
   localparam logic [7:0] DFU_APP_DETACH          = 8'd1;
   localparam logic [7:0] DFU_IDLE                = 8'd2;
   localparam logic [7:0] DFU_MANIFEST_WAIT_RESET = 8'd8;
   localparam logic [7:0] DFU_ERROR               = 8'd10;

   typedef logic [2:0] boot_state_t;

   localparam boot_state_t WAIT_LOCK = 3'd0;
   localparam boot_state_t POR       = 3'd1;
   localparam boot_state_t ENUM      = 3'd2;
   localparam boot_state_t STAY      = 3'd3;
   localparam boot_state_t DETACH    = 3'd4;
   localparam boot_state_t BOOT      = 3'd5;

   function automatic logic [31:0] sat_dec(input logic [31:0] v);
      return (v == 32'd0) ? 32'd0 : v - 32'd1;
   endfunction

endpackage

// File: rtl/dfu_led_pattern.sv
// Status LED pattern generator: free-running counter feeding a pattern mux
// selected by DFU state and whether the sequencer is still in its app phase.
module dfu_led_pattern
   import dfu_pkg::*;
#(
   parameter int unsigned CNT_W = 24
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] dfu_state,
   input  logic       mode,
   output logic       led
);

   logic [CNT_W-1:0] cnt_q;
   logic             led_q;
   logic             led_d;
   logic             idle;
   logic             busy;
   logic [4:0]       pwm;

   always_comb begin
      // Double blink: two short windows out of every eight phases.
      idle = (cnt_q[22:20] == 3'd3) || (cnt_q[22:20] == 3'd5);
      pwm  = cnt_q[23] ? cnt_q[22:18] : ~cnt_q[22:18];
      busy = (cnt_q[17:13] >= pwm);
      if (mode && (dfu_state == DFU_APP_IDLE)) begin
         led_d = ~idle;
      end else if (dfu_state == DFU_IDLE) begin
         led_d = idle;
      end else if (dfu_state == DFU_ERROR) begin
         led_d = cnt_q[21];
      end else begin
         led_d = busy;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= '0;
         led_q <= 1'b0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
         led_q <= led_d;
      end
   end

   assign led = led_q;

endmodule

// File: rtl/dfu_boot_ctrl.sv
// Boot/reset sequencer for the DFU bootloader: core power-on reset, auto-boot
// timeout, detach/warm-boot handling. Define DFU_MANIFEST_BOOT_EN to also boot
// on a bus reset seen in MANIFEST-WAIT-RESET.
module dfu_boot_ctrl
   import dfu_pkg::*;
#(
   parameter int unsigned POR_CYCLES   = 12000,
   parameter int unsigned BOOT_TIMEOUT = 36000000,
   parameter logic [1:0]  USER_IMAGE   = 2'd1,
   parameter int unsigned LED_CNT_W    = 24
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       pll_locked,
   input  logic [7:0] dfu_state,
   input  logic       usb_reset,
   output logic       core_reset,
   output logic       warm_boot,
   output logic [1:0] boot_sel,
   output logic       led
);

   localparam logic [31:0] POR_LOAD  = (POR_CYCLES > 0) ? 32'(POR_CYCLES - 1) : 32'd0;
   localparam logic [31:0] BOOT_LOAD = (BOOT_TIMEOUT > 0) ? 32'(BOOT_TIMEOUT - 1) : 32'd0;

   boot_state_t state_q, state_d;
   logic [31:0] por_cnt_q, por_cnt_d;
   logic [31:0] boot_cnt_q, boot_cnt_d;
   logic        core_reset_q, core_reset_d;
   logic        warm_boot_q, warm_boot_d;
   logic        app_phase;

   always_comb begin
      state_d    = state_q;
      por_cnt_d  = por_cnt_q;
      boot_cnt_d = boot_cnt_q;

      // Both counters start on the lock edge and only advance while locked.
      if (state_q == WAIT_LOCK) begin
         if (pll_locked) begin
            por_cnt_d  = POR_LOAD;
            boot_cnt_d = BOOT_LOAD;
         end
      end else if (pll_locked) begin
         por_cnt_d  = sat_dec(por_cnt_q);
         boot_cnt_d = sat_dec(boot_cnt_q);
      end

      case (state_q)
         WAIT_LOCK: begin
            if (pll_locked) begin
               state_d = POR;
            end
         end
         POR: begin
            if (por_cnt_q == 32'd0) begin
               state_d = ENUM;
            end
         end
         ENUM: begin
            if (dfu_state != DFU_APP_IDLE) begin
               state_d = STAY;
            end else if (boot_cnt_q == 32'd0) begin
               state_d = BOOT;
            end
         end
         STAY: begin
            if (dfu_state == DFU_APP_DETACH) begin
               state_d = DETACH;
            end
`ifdef DFU_MANIFEST_BOOT_EN
            else if ((dfu_state == DFU_MANIFEST_WAIT_RESET) && usb_reset) begin
               state_d = BOOT;
            end
`endif
         end
         DETACH: begin
            if (dfu_state != DFU_APP_DETACH) begin
               state_d = STAY;
            end else if (usb_reset) begin
               state_d = BOOT;
            end
         end
         BOOT: begin
            state_d = BOOT;
         end
         default: begin
            state_d = WAIT_LOCK;
         end
      endcase

      core_reset_d = (state_d == WAIT_LOCK) || (state_d == POR) || (state_d == BOOT);
      warm_boot_d  = (state_d == BOOT);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= WAIT_LOCK;
         por_cnt_q    <= POR_LOAD;
         boot_cnt_q   <= BOOT_LOAD;
         core_reset_q <= 1'b1;
         warm_boot_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         por_cnt_q    <= por_cnt_d;
         boot_cnt_q   <= boot_cnt_d;
         core_reset_q <= core_reset_d;
         warm_boot_q  <= warm_boot_d;
      end
   end

   assign app_phase = (state_q == WAIT_LOCK) || (state_q == POR) || (state_q == ENUM);

   dfu_led_pattern #(
      .CNT_W(LED_CNT_W)
   ) u_led (
      .clk      (clk),
      .reset_n  (reset_n),
      .dfu_state(dfu_state),
      .mode     (app_phase),
      .led      (led)
   );

   assign core_reset = core_reset_q;
   assign warm_boot  = warm_boot_q;
   assign boot_sel   = USER_IMAGE;

endmodule
